// File: rtl/pwm_capture.sv
//------------------------------------------------------------------------------
// Module : pwm_capture
// Purpose: Measures an incoming PWM waveform in the clk_100MHz domain.
//          Reports the last rise-to-rise period, the high time within that
//          period and a 2-bit quantised duty code (00=25%, 01=50%, 10=75%,
//          11=100%), and flags an input that has stopped toggling.
// Ports  : clk_100MHz  - system clock
//          reset       - asynchronous active-high reset
//          pwm_in      - asynchronous PWM input (synchronised internally)
//          period_cnt  - last measured period in clk cycles
//          high_cnt    - last measured high time in clk cycles
//          duty_code   - quantised duty of the last measurement
//          meas_valid  - one-cycle pulse when the three results update
//          locked      - a full period has been measured since reset/timeout
//          stuck_high  - input static high for TIMEOUT_CYCLES
//          stuck_low   - input static low for TIMEOUT_CYCLES
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_capture #(
  parameter int CNT_W          = 18,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [1:0]       duty_code,
  output logic             meas_valid,
  output logic             locked,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int               DW          = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             pwm_s_q;
  logic             pwm_d_q;
  logic [CNT_W-1:0] period_run_q;
  logic [CNT_W-1:0] high_run_q;
  logic [CNT_W-1:0] idle_run_q;
  logic [CNT_W-1:0] period_cnt_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [1:0]       duty_code_q;
  logic             meas_valid_q;
  logic             locked_q;
  logic             stuck_high_q;
  logic             stuck_low_q;

  logic [CNT_W-1:0] period_run_d;
  logic [CNT_W-1:0] high_run_d;
  logic [1:0]       duty_code_d;

  logic             rise;
  logic             edge_det;
  logic             timeout;

  logic [DW-1:0]    p_ext;
  logic [DW-1:0]    h8;
  logic [DW-1:0]    p3;
  logic [DW-1:0]    p5;
  logic [DW-1:0]    p7;

  assign rise     = pwm_s_q & ~pwm_d_q;
  assign edge_det = pwm_s_q ^ pwm_d_q;
  // An edge in the same cycle suppresses the timeout, so a rise always wins.
  assign timeout  = (idle_run_q == TIMEOUT_VAL) && !edge_det;

  // Saturating run counters; high time only advances while the input is high.
  always_comb begin
    period_run_d = (period_run_q == CNT_MAX) ? CNT_MAX : period_run_q + CNT_ONE;
    high_run_d   = high_run_q;
    if (pwm_s_q && (high_run_q != CNT_MAX)) begin
      high_run_d = high_run_q + CNT_ONE;
    end
  end

  // Duty thresholds at 3/8, 5/8, 7/8 of the period; equality rounds up.
  always_comb begin
    p_ext = DW'(period_run_q);
    h8    = {high_run_q, 3'b000};
    p3    = (p_ext << 1) + p_ext;
    p5    = (p_ext << 2) + p_ext;
    p7    = (p_ext << 3) - p_ext;
    if (h8 < p3) begin
      duty_code_d = 2'b00;
    end else if (h8 < p5) begin
      duty_code_d = 2'b01;
    end else if (h8 < p7) begin
      duty_code_d = 2'b10;
    end else begin
      duty_code_d = 2'b11;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_d_q      <= 1'b0;
      period_run_q <= '0;
      high_run_q   <= '0;
      idle_run_q   <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_code_q  <= 2'b00;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stuck_high_q <= 1'b0;
      stuck_low_q  <= 1'b0;
    end else begin
      sync1_q      <= pwm_in;
      pwm_s_q      <= sync1_q;
      pwm_d_q      <= pwm_s_q;
      meas_valid_q <= 1'b0;

      // Idle counter holds at the threshold so the timeout stays asserted
      // (idempotently) until the input moves again.
      if (edge_det) begin
        idle_run_q <= '0;
      end else if (idle_run_q != TIMEOUT_VAL) begin
        idle_run_q <= idle_run_q + CNT_ONE;
      end

      case (state_q)
        IDLE: begin
          if (rise) begin
            period_run_q <= CNT_ONE;
            high_run_q   <= CNT_ONE;
            state_q      <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_cnt_q <= period_run_q;
            high_cnt_q   <= high_run_q;
            duty_code_q  <= duty_code_d;
            meas_valid_q <= 1'b1;
            locked_q     <= 1'b1;
            // The rise cycle is the first cycle of the next period.
            period_run_q <= CNT_ONE;
            high_run_q   <= CNT_ONE;
          end else begin
            period_run_q <= period_run_d;
            high_run_q   <= high_run_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (edge_det) begin
        stuck_high_q <= 1'b0;
        stuck_low_q  <= 1'b0;
      end else if (timeout) begin
        state_q      <= IDLE;
        locked_q     <= 1'b0;
        stuck_high_q <= pwm_s_q;
        stuck_low_q  <= ~pwm_s_q;
      end
    end
  end

  assign period_cnt = period_cnt_q;
  assign high_cnt   = high_cnt_q;
  assign duty_code  = duty_code_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign stuck_high = stuck_high_q;
  assign stuck_low  = stuck_low_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
//------------------------------------------------------------------------------
// Module : tb_pwm_capture
// Purpose: Directed self-checking bench for pwm_capture. Inputs change on the
//          falling clock edge; outputs are sampled on the falling edge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pwm_capture;

  localparam int CNT_W   = 18;
  localparam int TIMEOUT = 5000;

  logic             clk;
  logic             reset;
  logic             pwm_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [1:0]       duty_code;
  logic             meas_valid;
  logic             locked;
  logic             stuck_high;
  logic             stuck_low;

  int tests_run = 0;
  int tests_fail = 0;
  int mv_count = 0;
  int mv_double = 0;
  logic mv_last = 1'b0;
  int base;

  pwm_capture #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .duty_code  (duty_code),
    .meas_valid (meas_valid),
    .locked     (locked),
    .stuck_high (stuck_high),
    .stuck_low  (stuck_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts meas_valid pulses and any pulse wider than 1 cycle.
  always @(posedge clk) begin
    #2;
    if (meas_valid) mv_count = mv_count + 1;
    if (meas_valid && mv_last) mv_double = mv_double + 1;
    mv_last = meas_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PWM period starting at a falling edge: high h cycles, low p-h cycles.
  task automatic drive_period(input int h, input int p);
    pwm_in = 1'b1;
    wait_neg(h);
    pwm_in = 1'b0;
    wait_neg(p - h);
  endtask

  // Drives one period (h,p) and checks the measurement of the previous
  // period, which must appear exactly 3 edges after this period's rise.
  task automatic period_chk(input int h, input int p, input int eh, input int ep,
                            input logic [1:0] ecode, input string tag);
    pwm_in = 1'b1;
    wait_neg(2);
    chk({tag, "_mv_early"}, {31'd0, meas_valid}, 32'd0);
    wait_neg(1);
    chk({tag, "_mv"},     {31'd0, meas_valid}, 32'd1);
    chk({tag, "_period"}, 32'(period_cnt), 32'(ep));
    chk({tag, "_high"},   32'(high_cnt), 32'(eh));
    chk({tag, "_code"},   {30'd0, duty_code}, {30'd0, ecode});
    chk({tag, "_locked"}, {31'd0, locked}, 32'd1);
    wait_neg(1);
    chk({tag, "_mv_drop"}, {31'd0, meas_valid}, 32'd0);
    wait_neg(h - 4);
    pwm_in = 1'b0;
    wait_neg(p - h);
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;

    // Reset held while the input toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    wait_neg(2);
    chk("rst_period", 32'(period_cnt), 32'd0);
    chk("rst_high",   32'(high_cnt), 32'd0);
    chk("rst_flags",  {26'd0, duty_code, meas_valid, locked, stuck_high, stuck_low}, 32'd0);

    pwm_in = 1'b0;
    wait_neg(1);
    reset = 1'b0;
    wait_neg(10);

    // First rise only arms.
    base = mv_count;
    drive_period(250, 1000);
    chk("arm_no_mv", 32'(mv_count - base), 32'd0);
    chk("arm_unlocked", {31'd0, locked}, 32'd0);

    // 25% steady wave, then duty sweep at P=1000.
    period_chk(250, 1000, 250, 1000, 2'b00, "p25a");
    period_chk(500, 1000, 250, 1000, 2'b00, "p25b");
    period_chk(750, 1000, 500, 1000, 2'b01, "p50");
    period_chk(999, 1000, 750, 1000, 2'b10, "p75");
    period_chk(375, 1000, 999, 1000, 2'b11, "p100");
    period_chk(374, 1000, 375, 1000, 2'b01, "thr375");
    period_chk(250, 1000, 374, 1000, 2'b00, "thr374");
    chk("sweep_no_double", 32'(mv_double), 32'd0);

    // Static high: the rise measures the last 25% period, then timeout.
    pwm_in = 1'b1;
    wait_neg(TIMEOUT + 10);
    chk("sh_stuck_high", {31'd0, stuck_high}, 32'd1);
    chk("sh_stuck_low",  {31'd0, stuck_low}, 32'd0);
    chk("sh_locked",     {31'd0, locked}, 32'd0);
    chk("sh_period_hold", 32'(period_cnt), 32'd1000);
    chk("sh_high_hold",   32'(high_cnt), 32'd250);

    // Resume: falling edge clears the flag, first rise re-arms only.
    base = mv_count;
    pwm_in = 1'b0;
    wait_neg(750);
    chk("sh_clear", {31'd0, stuck_high}, 32'd0);
    drive_period(250, 1000);
    chk("sh_rearm_no_mv", 32'(mv_count - base), 32'd0);
    chk("sh_rearm_unlocked", {31'd0, locked}, 32'd0);
    period_chk(250, 1000, 250, 1000, 2'b00, "sh_resume");

    // Static low.
    wait_neg(TIMEOUT + 10);
    chk("sl_stuck_low",  {31'd0, stuck_low}, 32'd1);
    chk("sl_stuck_high", {31'd0, stuck_high}, 32'd0);
    chk("sl_locked",     {31'd0, locked}, 32'd0);

    // Duty change 25% -> 75% at P=800.
    drive_period(200, 800);
    base = mv_count;
    period_chk(200, 800, 200, 800, 2'b00, "dc25a");
    period_chk(600, 800, 200, 800, 2'b00, "dc25b");
    period_chk(600, 800, 600, 800, 2'b10, "dc75");
    chk("dc_mv_count", 32'(mv_count - base), 32'd3);
    chk("dc_no_double", 32'(mv_double), 32'd0);

    // Reset pulse mid-period (input low): outputs clear asynchronously.
    pwm_in = 1'b1;
    wait_neg(200);
    pwm_in = 1'b0;
    wait_neg(300);
    reset = 1'b1;
    #1;
    chk("mr_period", 32'(period_cnt), 32'd0);
    chk("mr_high",   32'(high_cnt), 32'd0);
    chk("mr_flags",  {26'd0, duty_code, meas_valid, locked, stuck_high, stuck_low}, 32'd0);
    wait_neg(1);
    reset = 1'b0;
    wait_neg(299);
    base = mv_count;
    drive_period(200, 800);
    chk("mr_arm_no_mv", 32'(mv_count - base), 32'd0);
    period_chk(200, 800, 200, 800, 2'b00, "mr_meas");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

`default_nettype wire
